// File: rtl/rotate_sweep_pkg.sv
// Shared types for the rotate sweep sequencer: FSM state encoding and the
// data-width helper derived from the shift-amount width.
package rotate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  function automatic int data_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/sweep_dwell_counter.sv
// Free-running dwell counter: ticks on count == len-1 and wraps to zero on the
// tick, so consecutive ticks are exactly len cycles apart. len must be >= 1.
module sweep_dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic [DWELL_W-1:0] len,
  output logic               tick
);

  logic [DWELL_W-1:0] count;

  assign tick = (count == (len - DWELL_W'(1)));

  always_ff @(posedge clk) begin
    if (reset || clr || tick) begin
      count <= '0;
    end else begin
      count <= count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/rotate_sweep_ctrl.sv
// Drives a barrel shifter's a/amt through every shift amount, holding each
// for dwell_q cycles and capturing the shifter result at the end of each hold.
module rotate_sweep_ctrl
  import rotate_sweep_pkg::*;
#(
  parameter  int N       = 3,
  parameter  int DWELL_W = 16,
  localparam int W       = data_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic [W-1:0]       data_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [W-1:0]       y_in,
  output logic [W-1:0]       a,
  output logic [N-1:0]       amt,
  output logic [W-1:0]       y_q,
  output logic               cap_valid,
  output logic               busy,
  output logic               done
);

  sweep_state_t       state, next_state;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q;
  logic               tick;
  logic               load;
  logic               capture;
  logic               last_amt;

  assign last_amt = dir_q ? (amt == '0) : (amt == N'(W - 1));
  assign busy     = (state == RUN);

  // Counter is held clear outside RUN so every sweep starts a fresh hold.
  sweep_dwell_counter #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (state != RUN),
    .len  (dwell_q),
    .tick (tick)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        // stop beats a same-cycle capture: the abort leaves y_q untouched.
        if (stop) begin
          next_state = IDLE;
        end else if (tick) begin
          capture = 1'b1;
          if (last_amt) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a         <= '0;
      amt       <= '0;
      y_q       <= '0;
      cap_valid <= 1'b0;
      done      <= 1'b0;
      dwell_q   <= DWELL_W'(1);
      dir_q     <= 1'b0;
    end else begin
      state     <= next_state;
      cap_valid <= capture;
      done      <= (state == DONE);
      if (load) begin
        a       <= data_in;
        dir_q   <= dir;
        dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
        amt     <= dir ? N'(W - 1) : '0;
      end
      if (capture) begin
        y_q <= y_in;
        if (!last_amt) amt <= dir_q ? (amt - N'(1)) : (amt + N'(1));
      end
    end
  end

endmodule

// File: tb/tb_rotate_sweep_ctrl.sv
// Randomized bench for rotate_sweep_ctrl with a rotate-right shifter model on
// y_in, a capture scoreboard and directed abort/reset scenarios.
module tb_rotate_sweep_ctrl;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, stop, dir;
  logic [W-1:0]  data_in, y_in, a, y_q;
  logic [DW-1:0] dwell;
  logic [N-1:0]  amt;
  logic          cap_valid, busy, done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  logic [W-1:0] mon_e;
  int           mon_t;
  logic [W-1:0] last_y;

  rotate_sweep_ctrl #(.N(N), .DWELL_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir),
    .data_in(data_in), .dwell(dwell), .y_in(y_in), .a(a), .amt(amt),
    .y_q(y_q), .cap_valid(cap_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[(i + s) % W];
    return r;
  endfunction

  assign y_in = ror(a, int'(amt));

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every capture pulse must match the next expected value and cycle.
  always @(negedge clk) begin
    if (cap_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cap", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        check("y_q", y_q, mon_e);
        check("cap_cycle", cyc, mon_t);
      end
    end
  end

  function automatic int eff_dwell(input int dw);
    return (dw == 0) ? 1 : dw;
  endfunction

  function automatic int amt_at(input int k, input bit dr);
    return dr ? (W - 1 - k) : k;
  endfunction

  // Issue start and push the first n_caps expected captures of the sweep.
  task automatic do_start(input logic [W-1:0] d, input int dw, input bit dr,
                          input int n_caps, input bit with_stop);
    int e0;
    int eff;
    @(posedge clk);
    #1;
    start   = 1'b1;
    stop    = with_stop;
    data_in = d;
    dwell   = DW'(dw);
    dir     = dr;
    @(posedge clk);
    #1;
    start   = 1'b0;
    stop    = 1'b0;
    data_in = $urandom;
    dwell   = DW'($urandom_range(0, 7));
    dir     = $urandom_range(0, 1);
    e0  = cyc;
    eff = eff_dwell(dw);
    for (int k = 0; k < n_caps; k++) begin
      exp_q.push_back(ror(d, amt_at(k, dr)));
      exp_t_q.push_back(e0 + (k + 1) * eff);
      last_y = ror(d, amt_at(k, dr));
    end
  endtask

  task automatic check_first(input logic [W-1:0] d, input bit dr);
    check("a_loaded", a, d);
    check("amt_first", amt, amt_at(0, dr));
    check("busy_run", busy, 1);
  endtask

  task automatic run_sweep(input logic [W-1:0] d, input int dw, input bit dr,
                           input bit inject, input bit with_stop);
    int n;
    int lim;
    bit seen;
    do_start(d, dw, dr, W, with_stop);
    lim  = W * eff_dwell(dw) + 12;
    n    = 0;
    seen = 1'b0;
    while (n < lim) begin
      @(negedge clk);
      if (n == 0) check_first(d, dr);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (inject && n == 2) begin
        start   = 1'b1;
        data_in = ~d;
        dir     = ~dr;
        dwell   = DW'(5);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    check("done_seen", seen, 1);
    check("done_latency", n, W * eff_dwell(dw) + 1);
    check("busy_at_done", busy, 0);
    check("final_y_q", y_q, ror(d, amt_at(W - 1, dr)));
    check("final_amt", amt, amt_at(W - 1, dr));
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic abort_sweep(input logic [W-1:0] d, input int dw, input bit dr,
                             input int stop_cyc);
    int n_caps;
    int dones;
    logic [W-1:0] prev_y;
    prev_y = y_q;
    n_caps = (stop_cyc - 1) / eff_dwell(dw);
    do_start(d, dw, dr, n_caps, 1'b0);
    for (int n = 0; n < stop_cyc; n++) begin
      @(negedge clk);
      if (n == 0) check_first(d, dr);
      if (n == stop_cyc - 1) stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
    end
    @(negedge clk);
    check("busy_after_stop", busy, 0);
    check("y_q_held", y_q, (n_caps > 0) ? last_y : prev_y);
    dones = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_stop", dones, 0);
    check("stop_queue_drained", exp_q.size(), 0);
  endtask

  task automatic reset_mid(input logic [W-1:0] d, input int dw, input bit dr,
                           input int after);
    int dones;
    do_start(d, dw, dr, W, 1'b0);
    repeat (after) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    @(negedge clk);
    check("reset_mid_outputs", {a, amt, y_q, cap_valid, busy, done}, 0);
    dones = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || cap_valid || busy) dones++;
    end
    check("quiet_after_reset", dones, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    dir     = 1'b0;
    data_in = '0;
    dwell   = '0;
    last_y  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {a, amt, y_q, cap_valid, busy, done}, 0);

    // stop alone in IDLE must not start anything
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    check("stop_in_idle", busy, 0);

    run_sweep(8'h11, 1, 1'b0, 1'b0, 1'b0);
    run_sweep(8'h01, 3, 1'b1, 1'b0, 1'b0);
    run_sweep(8'h11, 0, 1'b0, 1'b0, 1'b0);
    abort_sweep(8'hA5, 2, 1'b0, 4);
    run_sweep(8'h3C, 2, 1'b0, 1'b1, 1'b0);
    run_sweep(8'h81, 1, 1'b1, 1'b0, 1'b1);
    reset_mid(8'h5A, 2, 1'b0, 5);
    run_sweep(8'hC3, 1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_sweep(W'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 3; r++) begin
      abort_sweep(W'($urandom), 3, 1'($urandom_range(0, 1)),
                  $urandom_range(1, W * 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
